// File: rtl/pipe_stage_buf_pkg.sv
// rtl/pipe_stage_buf_pkg.sv - shared types and constants for the elastic pipeline stage buffer
package pipe_stage_buf_pkg;

    localparam int PIPE_BUF_DEPTH_DEFAULT = 2;
    localparam int LC3B_WORD_W            = 16;
    localparam int LC3B_REG_W             = 3;

    typedef enum logic [3:0] {
        OP_BR   = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_LDB  = 4'b0010,
        OP_STB  = 4'b0011,
        OP_JSR  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_LDR  = 4'b0110,
        OP_STR  = 4'b0111,
        OP_RTI  = 4'b1000,
        OP_NOT  = 4'b1001,
        OP_LDI  = 4'b1010,
        OP_STI  = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_SHF  = 4'b1101,
        OP_LEA  = 4'b1110,
        OP_TRAP = 4'b1111
    } lc3b_opcode_e;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'd0,
        ALU_AND  = 2'd1,
        ALU_NOT  = 2'd2,
        ALU_PASS = 2'd3
    } lc3b_aluop_e;

    // Control word carried alongside each instruction through every stage.
    typedef struct packed {
        lc3b_opcode_e opcode;
        lc3b_aluop_e  aluop;
        logic         load_regfile;
        logic         load_cc;
        logic         mem_read;
        logic         mem_write;
        logic         mem_byte;
        logic         is_branch;
    } lc3b_ctrl_word;

    typedef struct packed {
        lc3b_ctrl_word            ctrl;
        logic [LC3B_WORD_W-1:0]   pc;
        logic [LC3B_WORD_W-1:0]   instruction;
        logic [LC3B_REG_W-1:0]    src1;
        logic [LC3B_REG_W-1:0]    src2;
        logic [LC3B_REG_W-1:0]    dest;
        logic [LC3B_WORD_W-1:0]   src1_data;
        logic [LC3B_WORD_W-1:0]   src2_data;
        logic [LC3B_WORD_W-1:0]   dest_data;
    } lc3b_stage_payload;

    // Pointer width that stays >= 1 even for a single-entry buffer.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipe_stage_buf_if.sv
// rtl/pipe_stage_buf_if.sv - valid/ready handshake, flush and status bundle of the stage buffer
interface pipe_stage_buf_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
);
    localparam int COUNT_W = $clog2(DEPTH + 1);

    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [COUNT_W-1:0] count;
    logic [CNT_W-1:0]   stall_cycles;
    logic [CNT_W-1:0]   bubble_cycles;

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count, stall_cycles, bubble_cycles
    );

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count, stall_cycles, bubble_cycles
    );
endinterface

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - elastic FWFT pipeline register with flush; PIPE_BUF_PERF_EN adds stall/bubble counters
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = PIPE_BUF_DEPTH_DEFAULT,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    pipe_stage_buf_if.slave  bus
);
    localparam int COUNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W   = ptr_width(DEPTH);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [COUNT_W-1:0] count_q;
    logic               push;
    logic               pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // in_ready depends only on registered occupancy, so a full buffer stays closed even while popping.
    assign bus.in_ready  = (count_q != COUNT_W'(DEPTH)) && !bus.flush;
    assign bus.out_valid = (count_q != '0);
    assign bus.out_data  = mem[rd_ptr];
    assign bus.count     = count_q;

    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready & ~bus.flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + COUNT_W'(1);
                2'b01:   count_q <= count_q - COUNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entries are zeroed on reset so out_data reads 0 while reset is held; flush leaves them as-is.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

`ifdef PIPE_BUF_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] bubble_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else if (bus.flush) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (bus.out_valid && !bus.out_ready) begin
                stall_q <= sat_inc(stall_q);
            end
            if (!bus.out_valid && bus.out_ready) begin
                bubble_q <= sat_inc(bubble_q);
            end
        end
    end

    assign bus.stall_cycles  = stall_q;
    assign bus.bubble_cycles = bubble_q;
`else
    assign bus.stall_cycles  = {CNT_W{1'b0}};
    assign bus.bubble_cycles = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - directed vector bench for pipe_stage_buf (DEPTH=2 and DEPTH=3 instances)
module tb_pipe_stage_buf;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    pipe_stage_buf_if #(.WIDTH(16), .DEPTH(2), .CNT_W(4)) bus_a();
    pipe_stage_buf_if #(.WIDTH(16), .DEPTH(3), .CNT_W(4)) bus_b();

    pipe_stage_buf #(.WIDTH(16), .DEPTH(2), .CNT_W(4)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    pipe_stage_buf #(.WIDTH(16), .DEPTH(3), .CNT_W(4)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    typedef struct {
        logic        fl;
        logic        iv;
        logic [15:0] d;
        logic        rdy;
        logic        ov;
        logic [15:0] od;
        logic [1:0]  cnt;
        logic        ir;
    } vec_t;

    int tests = 0;
    int fails = 0;
    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic fl, input logic iv, input logic [15:0] d, input logic rdy,
                                input logic ov, input logic [15:0] od, input logic [1:0] cnt, input logic ir);
        vec_t v;
        v.fl = fl; v.iv = iv; v.d = d; v.rdy = rdy;
        v.ov = ov; v.od = od; v.cnt = cnt; v.ir = ir;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] sb[$];
        int          received;
        int          pushed;

        // fl iv data rdy | ov od cnt ir  (expected values are pre-edge, with inputs applied)
        vecs[0]  = mk(0, 1, 16'h1111, 0,  0, 16'h0000, 0, 1);
        vecs[1]  = mk(0, 1, 16'h2222, 0,  1, 16'h1111, 1, 1);
        vecs[2]  = mk(0, 0, 16'h0000, 1,  1, 16'h1111, 2, 0);
        vecs[3]  = mk(0, 0, 16'h0000, 1,  1, 16'h2222, 1, 1);
        vecs[4]  = mk(0, 0, 16'h0000, 0,  0, 16'h0000, 0, 1);
        vecs[5]  = mk(0, 1, 16'h3333, 0,  0, 16'h0000, 0, 1);
        vecs[6]  = mk(0, 1, 16'h4444, 0,  1, 16'h3333, 1, 1);
        vecs[7]  = mk(0, 1, 16'h5555, 1,  1, 16'h3333, 2, 0);
        vecs[8]  = mk(0, 1, 16'h5555, 1,  1, 16'h4444, 1, 1);
        vecs[9]  = mk(0, 0, 16'h0000, 1,  1, 16'h5555, 1, 1);
        vecs[10] = mk(0, 0, 16'h0000, 0,  0, 16'h0000, 0, 1);
        vecs[11] = mk(0, 1, 16'h6666, 0,  0, 16'h0000, 0, 1);
        vecs[12] = mk(0, 1, 16'h7777, 0,  1, 16'h6666, 1, 1);
        vecs[13] = mk(1, 1, 16'hBEEF, 1,  1, 16'h6666, 2, 0);
        vecs[14] = mk(0, 0, 16'h0000, 1,  0, 16'h0000, 0, 1);
        vecs[15] = mk(0, 1, 16'h8888, 1,  0, 16'h0000, 0, 1);
        vecs[16] = mk(0, 0, 16'h0000, 1,  1, 16'h8888, 1, 1);
        vecs[17] = mk(0, 0, 16'h0000, 0,  0, 16'h0000, 0, 1);

        reset_n = 1'b0;
        bus_a.flush = 0; bus_a.in_valid = 0; bus_a.in_data = '0; bus_a.out_ready = 0;
        bus_b.flush = 0; bus_b.in_valid = 0; bus_b.in_data = '0; bus_b.out_ready = 0;
        #12;
        check("rst_out_valid", bus_a.out_valid, 0);
        check("rst_out_data", bus_a.out_data, 0);
        check("rst_count", bus_a.count, 0);
        check("rst_in_ready", bus_a.in_ready, 1);
        check("rst_stall", bus_a.stall_cycles, 0);
        check("rst_bubble", bus_a.bubble_cycles, 0);
        bus_a.flush = 1;
        #1;
        check("rst_flush_in_ready", bus_a.in_ready, 0);
        bus_a.flush = 0;
        #9;
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 18; i++) begin
            bus_a.flush     = vecs[i].fl;
            bus_a.in_valid  = vecs[i].iv;
            bus_a.in_data   = vecs[i].d;
            bus_a.out_ready = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d_out_valid", i), bus_a.out_valid, vecs[i].ov);
            if (vecs[i].ov) check($sformatf("vec%0d_out_data", i), bus_a.out_data, vecs[i].od);
            check($sformatf("vec%0d_count", i), bus_a.count, vecs[i].cnt);
            check($sformatf("vec%0d_in_ready", i), bus_a.in_ready, vecs[i].ir);
            if (i >= 14) check($sformatf("vec%0d_no_beef", i), bus_a.out_data == 16'hBEEF, 0);
            tick();
        end

        // Throughput: data 0..7 streamed with out_ready held high
        for (int c = 0; c < 10; c++) begin
            bus_a.flush     = 0;
            bus_a.in_valid  = (c < 8);
            bus_a.in_data   = 16'(c);
            bus_a.out_ready = 1;
            #1;
            if (c >= 1 && c <= 8) begin
                check($sformatf("thru%0d_valid", c), bus_a.out_valid, 1);
                check($sformatf("thru%0d_data", c), bus_a.out_data, 32'(c - 1));
            end else begin
                check($sformatf("thru%0d_valid", c), bus_a.out_valid, 0);
            end
            tick();
        end
        bus_a.in_valid = 0; bus_a.out_ready = 0;

        // Wrap on DEPTH=3 with random downstream backpressure
        received = 0;
        pushed   = 0;
        for (int c = 0; c < 300 && received < 10; c++) begin
            bus_b.in_valid  = (pushed < 10);
            bus_b.in_data   = 16'hA0 + 16'(pushed);
            bus_b.out_ready = (pushed >= 10) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            if (bus_b.count > 3) check("wrap_count_max", bus_b.count, 3);
            if (bus_b.out_valid && bus_b.out_ready) begin
                if (sb.size() == 0) begin
                    check("wrap_spurious", bus_b.out_data, 16'hFFFF);
                end else begin
                    check($sformatf("wrap_order%0d", received), bus_b.out_data, sb.pop_front());
                end
                received++;
            end
            if (bus_b.in_valid && bus_b.in_ready) begin
                sb.push_back(bus_b.in_data);
                pushed++;
            end
            tick();
        end
        check("wrap_received", received, 10);
        bus_b.in_valid = 0; bus_b.out_ready = 0;

        // Asynchronous reset while one entry is held
        bus_a.in_valid = 1; bus_a.in_data = 16'hABCD; bus_a.out_ready = 0;
        tick();
        bus_a.in_valid = 0;
        #1;
        check("pre_rst_count", bus_a.count, 1);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_rst_out_valid", bus_a.out_valid, 0);
        check("async_rst_out_data", bus_a.out_data, 0);
        check("async_rst_count", bus_a.count, 0);
        #2;
        reset_n = 1'b1;
        bus_a.in_valid = 1; bus_a.in_data = 16'hCAFE;
        tick();
        bus_a.in_valid = 0;
        #1;
        check("post_rst_valid", bus_a.out_valid, 1);
        check("post_rst_data", bus_a.out_data, 16'hCAFE);
        check("post_rst_count", bus_a.count, 1);
        bus_a.out_ready = 1;
        tick();
        bus_a.out_ready = 0;
        #1;
        check("post_rst_drained", bus_a.count, 0);

        // Stall counter: clear with flush, then hold one entry for 20 cycles
        bus_a.flush = 1;
        tick();
        bus_a.flush = 0;
        #1;
        check("perf_cleared", bus_a.stall_cycles, 0);
        bus_a.in_valid = 1; bus_a.in_data = 16'h1234;
        tick();
        bus_a.in_valid = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (c == 5) begin
`ifdef PIPE_BUF_PERF_EN
                check("perf_stall_mid", bus_a.stall_cycles, 6);
`else
                check("perf_stall_mid", bus_a.stall_cycles, 0);
`endif
            end
        end
        #1;
        check("perf_hold_data", bus_a.out_data, 16'h1234);
`ifdef PIPE_BUF_PERF_EN
        check("perf_stall_sat", bus_a.stall_cycles, 15);
`else
        check("perf_stall_off", bus_a.stall_cycles, 0);
        check("perf_bubble_off", bus_a.bubble_cycles, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
